imem_loader: RTL

- Writer side of the byte-addressable, little-endian instruction memory used by the multi-cycle MIPS core.
- Accepts 32-bit instruction words over a valid/ready stream and writes each word into the memory's byte array, one byte per cycle, starting at a programmable base address.
- Sits between a program source (testbench, UART front end, boot ROM) and the write port of a writable instruction memory. Runs before the core is released from reset.

---
 rtl/mips_mem_pkg.sv | 24 ++
 rtl/imem_word_serializer.sv | 42 ++++
 rtl/imem_loader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS instruction-memory loader path.
package mips_mem_pkg;

  localparam int unsigned IMEM_ADR_W     = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    VERIFY,
    DONE
  } loader_state_e;

  // Little-endian lane select: lane 0 is bits [7:0].
  function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] word,
                                                input logic [LANE_W-1:0] k);
    return word[BYTE_W*k +: BYTE_W];
  endfunction

endpackage

// File: rtl/imem_word_serializer.sv
// Holds one instruction word and presents it byte by byte (lane 0 first),
// with byte, lane offset and last-lane flag all registered.
module imem_word_serializer
  import mips_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              advance,
  input  logic              rewind,
  output logic [BYTE_W-1:0] data_byte,
  output logic [LANE_W-1:0] offset,
  output logic              last
);

  logic [WORD_W-1:0] word_q;

  // Rewind replays the held word from lane 0 for readback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      data_byte <= '0;
      offset    <= '0;
      last      <= 1'b0;
    end else if (load) begin
      word_q    <= word;
      data_byte <= byte_of(word, LANE_W'(0));
      offset    <= '0;
      last      <= 1'b0;
    end else if (rewind) begin
      data_byte <= byte_of(word_q, LANE_W'(0));
      offset    <= '0;
      last      <= 1'b0;
    end else if (advance) begin
      data_byte <= byte_of(word_q, offset + LANE_W'(1));
      offset    <= offset + LANE_W'(1);
      last      <= (offset == LANE_W'(BYTES_PER_WORD - 2));
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory.
// Define IMEM_VERIFY_EN to add a readback pass after each word's writes.
module imem_loader
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADR_W = IMEM_ADR_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  base_adr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_loaded
`ifdef IMEM_VERIFY_EN
  ,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              verify_err
`endif
);

`ifdef IMEM_VERIFY_EN
  localparam loader_state_e LAST_PHASE = VERIFY;
`else
  localparam loader_state_e LAST_PHASE = WRITE;
`endif

  loader_state_e     state;
  logic [ADR_W-1:0]  addr;
  logic [ADR_W-1:0]  next_adr;
  logic [CNT_W-1:0]  remaining;
  logic              ser_load;
  logic              ser_adv;
  logic              ser_rewind;
  logic              ser_last;
  logic [LANE_W-1:0] ser_offset;
  logic              word_end;

  assign ser_load = in_ready && in_valid;
  assign ser_adv  = ((state == WRITE) || (state == VERIFY)) && !ser_last;
  assign word_end = (state == LAST_PHASE) && ser_last;
  assign next_adr = addr + ADR_W'(ser_offset) + ADR_W'(1);
`ifdef IMEM_VERIFY_EN
  assign ser_rewind = (state == WRITE) && ser_last;
`else
  assign ser_rewind = 1'b0;
`endif

  imem_word_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .word      (in_data),
    .advance   (ser_adv),
    .rewind    (ser_rewind),
    .data_byte (mem_wdata),
    .offset    (ser_offset),
    .last      (ser_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
      mem_adr      <= '0;
      addr         <= '0;
      remaining    <= '0;
`ifdef IMEM_VERIFY_EN
      verify_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr         <= base_adr;
            remaining    <= word_count;
            words_loaded <= '0;
`ifdef IMEM_VERIFY_EN
            verify_err   <= 1'b0;
`endif
            if (word_count == CNT_W'(0)) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else begin
              state    <= ACCEPT;
              done     <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            state    <= WRITE;
            in_ready <= 1'b0;
            mem_we   <= 1'b1;
            mem_adr  <= addr;
          end
        end
        WRITE: begin
          if (!ser_last) begin
            mem_adr <= next_adr;
          end
`ifdef IMEM_VERIFY_EN
          else begin
            state   <= VERIFY;
            mem_we  <= 1'b0;
            mem_adr <= addr;
          end
`endif
        end
`ifdef IMEM_VERIFY_EN
        VERIFY: begin
          if (mem_rdata != mem_wdata) verify_err <= 1'b1;
          if (!ser_last) mem_adr <= next_adr;
        end
`endif
        default: state <= IDLE;
      endcase

      // Word retired: advance address and counters, then fetch next or finish.
      if (word_end) begin
        mem_we       <= 1'b0;
        addr         <= addr + ADR_W'(BYTES_PER_WORD);
        words_loaded <= words_loaded + CNT_W'(1);
        remaining    <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state    <= ACCEPT;
          in_ready <= 1'b1;
        end
      end
    end
  end

endmodule
